// File: rtl/rxd_ctrl.sv
// rtl/rxd_ctrl.sv - UART receive sequencer driving a 10-bit right-shift register
module rxd_ctrl #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic serial_out,
  output logic sh_clr,
  output logic sh_en,
  output logic sh_load,
  output logic rx_done,
  output logic frame_err,
  output logic busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_BIT - 1);
  // bit_cnt value after the D7 shift, and the marker for "stop shifted, load pending"
  localparam logic [3:0]    LAST_DATA = 4'd9;
  localparam logic [3:0]    LOAD_PEND = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic          sync1_q, sync2_q;
  logic          sh_clr_q, sh_clr_d;
  logic          sh_en_q, sh_en_d;
  logic          sh_load_q, sh_load_d;
  logic          frame_err_q, frame_err_d;

  logic rxd_s;
  assign rxd_s = sync2_q;

  // Two-flop synchroniser for the asynchronous serial line; idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered one-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      sh_clr_q    <= 1'b0;
      sh_en_q     <= 1'b0;
      sh_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      sh_clr_q    <= sh_clr_d;
      sh_en_q     <= sh_en_d;
      sh_load_q   <= sh_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: start detect, half-bit qualify, bit-centre sampling, stop check
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    sh_clr_d    = 1'b0;
    sh_en_d     = 1'b0;
    sh_load_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rxd_s) begin
          state_d  = S_START;
          sh_clr_d = 1'b1;
        end
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            sh_en_d = 1'b1;
            bit_d   = 4'd1;
            state_d = S_DATA;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          sh_en_d = 1'b1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_DATA - 4'd1) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        // Load waits one cycle so the shift register has closed the 10th shift
        if (bit_q == LOAD_PEND) begin
          sh_load_d = 1'b1;
          state_d   = S_IDLE;
        end else if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          sh_en_d = 1'b1;
          if (rxd_s) begin
            bit_d = LOAD_PEND;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_BRK: begin
        baud_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign serial_out = rxd_s;
  assign sh_clr     = sh_clr_q;
  assign sh_en      = sh_en_q;
  assign sh_load    = sh_load_q;
  assign rx_done    = sh_load_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rxd_ctrl.sv
// tb/tb_rxd_ctrl.sv - randomized self-checking bench for rxd_ctrl
module tb_rxd_ctrl;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic serial_out, sh_clr, sh_en, sh_load, rx_done, frame_err, busy;

  always #5 clk = ~clk;

  rxd_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .serial_out (serial_out),
    .sh_clr     (sh_clr),
    .sh_en      (sh_en),
    .sh_load    (sh_load),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observer: shift register model and event counters, sampled mid-cycle
  int         cyc = 0;
  int         en_cnt = 0, load_cnt = 0, ferr_cnt = 0, busy_cnt = 0, done_err = 0;
  logic [9:0] sreg = '0;
  logic [9:0] got_q[$];
  int         en_t[$];

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (rx_done !== sh_load) done_err++;
    if (sh_clr) sreg = '0;
    if (sh_en) begin
      en_cnt++;
      en_t.push_back(cyc);
      sreg = {serial_out, sreg[9:1]};
    end
    if (frame_err) ferr_cnt++;
    if (sh_load) begin
      load_cnt++;
      got_q.push_back(sreg);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serial frame as it appears on the line: start, D0..D7, stop
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] line;
    line = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = line[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop_ok, input int gap);
    int e0, l0, f0, t0, g0;
    logic [9:0] fr;
    e0 = en_cnt; l0 = load_cnt; f0 = ferr_cnt; t0 = en_t.size(); g0 = got_q.size();
    send_frame(b, stop_ok);
    idle(gap);
    chk("sh_en_count", en_cnt - e0, 10);
    chk("load_count", load_cnt - l0, {31'd0, stop_ok});
    chk("frame_err_count", ferr_cnt - f0, {31'd0, !stop_ok});
    chk("busy_after_frame", {31'd0, busy}, 0);
    if (en_t.size() - t0 == 10) chk("sh_en_span", en_t[t0+9] - en_t[t0], 9 * CPB);
    if (stop_ok && got_q.size() > g0) begin
      fr = got_q[g0];
      chk("data", {24'd0, fr[8:1]}, {24'd0, b});
      chk("start_bit", {31'd0, fr[0]}, 0);
      chk("stop_bit", {31'd0, fr[9]}, 1);
    end
  endtask

  initial begin
    int e0, l0, f0, b0, g0;
    logic [9:0] fr;
    logic [7:0] rb;
    logic       rs;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_serial_out", {31'd0, serial_out}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_strobes", {27'd0, sh_clr, sh_en, sh_load, rx_done, frame_err}, 0);
    reset = 1'b0;
    idle(4);

    // Good frame
    run_frame(8'hA5, 1'b1, 6);

    // Short low glitch: qualify fails at half bit
    e0 = en_cnt; l0 = load_cnt; b0 = busy_cnt;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(14);
    chk("glitch_sh_en", en_cnt - e0, 0);
    chk("glitch_load", load_cnt - l0, 0);
    chk("glitch_busy_cycles", busy_cnt - b0, HALF);

    // Bad stop bit, line held low afterwards, then recovery
    e0 = en_cnt; l0 = load_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (16) @(negedge clk);
    chk("brk_busy", {31'd0, busy}, 1);
    chk("brk_frame_err", ferr_cnt - f0, 1);
    chk("brk_load", load_cnt - l0, 0);
    chk("brk_sh_en", en_cnt - e0, 10);
    idle(5);
    chk("brk_release_busy", {31'd0, busy}, 0);
    run_frame(8'h81, 1'b1, 6);

    // Reset after four shifts aborts at once
    e0 = en_cnt;
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0) ? 1'b0 : ((8'h55 >> (i - 1)) & 1);
      repeat (CPB) @(negedge clk);
    end
    chk("pre_reset_shifts", en_cnt - e0, 4);
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", {31'd0, busy}, 0);
    chk("mid_reset_strobes", {27'd0, sh_clr, sh_en, sh_load, rx_done, frame_err}, 0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(4);
    run_frame(8'h55, 1'b1, 6);

    // Back-to-back frames, no idle between stop and next start
    e0 = en_cnt; l0 = load_cnt; g0 = got_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(6);
    chk("b2b_sh_en", en_cnt - e0, 20);
    chk("b2b_loads", load_cnt - l0, 2);
    if (got_q.size() >= g0 + 2) begin
      fr = got_q[g0];
      chk("b2b_first", {24'd0, fr[8:1]}, 32'h00);
      fr = got_q[g0+1];
      chk("b2b_second", {24'd0, fr[8:1]}, 32'hFF);
    end

    // Line held low for 30 bit times
    e0 = en_cnt; l0 = load_cnt; f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    chk("held_low_frame_err", ferr_cnt - f0, 1);
    chk("held_low_load", load_cnt - l0, 0);
    chk("held_low_sh_en", en_cnt - e0, 10);
    chk("held_low_busy", {31'd0, busy}, 1);
    idle(5);
    chk("held_low_release", {31'd0, busy}, 0);

    // Randomized frames with random stop validity and idle gaps
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      run_frame(rb, rs, $urandom_range(4, 20));
    end

    chk("rx_done_tracks_load", done_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
